// File: rtl/cnn_pkg.sv
// Shared CNN widths, OFM writer state type and the accumulator requantizer.
// Requantize: round-half-up arithmetic shift, then saturate to signed OUT_W.
// OFM_WRITER_RELU_EN: when defined, negative requantized results become zero.
package cnn_pkg;

    localparam int ACC_W     = 20;
    localparam int OUT_W     = 8;
    localparam int ADDR_W    = 8;
    localparam int OFM_WORDS = 176;
    localparam int OUT_MAX   = 127;
    localparam int OUT_MIN   = -128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ofm_wr_state_t;

    // One guard bit above ACC_W keeps the rounding add from overflowing.
    function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] x,
                                                 input int unsigned    shift);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] half;
        logic signed [ACC_W:0] t;
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        logic [OUT_W-1:0]      r;
        ext  = {x[ACC_W-1], x};
        half = (ACC_W+1)'(1) << (shift - 1);
        t    = (ext + half) >>> shift;
        hi   = (ACC_W+1)'(OUT_MAX);
        lo   = (ACC_W+1)'(OUT_MIN);
        if (t > hi) begin
            r = OUT_W'(hi);
        end else if (t < lo) begin
            r = OUT_W'(lo);
        end else begin
            r = OUT_W'(t);
        end
`ifdef OFM_WRITER_RELU_EN
        if (r[OUT_W-1]) begin
            r = '0;
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/ofm_fifo.sv
// Small synchronous FIFO with first-word fall-through read data; DEPTH power of two, >= 2.
// Latency: pushed word visible on dout the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
module ofm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/ofm_writer.sv
// Requantizes accumulator results and writes one OFM of OFM_WORDS pixels at addresses 0..OFM_WORDS-1.
// Latency: sample accepted at edge N is written (wren) from edge N+1; one sample per cycle sustained.
// Backpressure: in_ready low outside RUN, when the FIFO is full or the map is fully accepted. OFM_WRITER_RELU_EN clamps negatives.
module ofm_writer
    import cnn_pkg::*;
#(
    parameter int ACC_W      = cnn_pkg::ACC_W,
    parameter int OUT_W      = cnn_pkg::OUT_W,
    parameter int ADDR_W     = cnn_pkg::ADDR_W,
    parameter int OFM_WORDS  = cnn_pkg::OFM_WORDS,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_W-1:0]  in_data,
    output logic [ADDR_W-1:0] address,
    output logic [OUT_W-1:0]  wrData,
    output logic              wren,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(OFM_WORDS + 1);

    ofm_wr_state_t    state;
    ofm_wr_state_t    state_nxt;
    logic             start_run;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             last_pop;
    logic [OUT_W-1:0] q_pix;
    logic [OUT_W-1:0] fifo_dout;

    assign in_ready = (state == RUN) && !fifo_full && (acc_cnt < CNT_W'(OFM_WORDS));
    assign push     = in_valid && in_ready;
    assign pop      = (state == RUN) && !fifo_empty;
    assign last_pop = pop && (wr_cnt == CNT_W'(OFM_WORDS - 1));
    assign q_pix    = requant(in_data, SHIFT);

    ofm_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (q_pix),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                if (last_pop) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc_cnt <= '0;
            wr_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (start_run) begin
                acc_cnt <= '0;
                wr_cnt  <= '0;
            end else begin
                if (push) begin
                    acc_cnt <= acc_cnt + 1'b1;
                end
                if (pop) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

    // busy stays up through the final write cycle even though the FSM has already moved to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wren    <= 1'b0;
            address <= '0;
            wrData  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wren <= pop;
            if (pop) begin
                address <= ADDR_W'(wr_cnt);
                wrData  <= fifo_dout;
            end
            busy <= (state_nxt == RUN) || last_pop;
            done <= (state_nxt == DONE) && !last_pop;
        end
    end

endmodule

// File: tb/tb_ofm_writer.sv
// Self-checking bench for ofm_writer: vector table, corner sequences and a randomized run
// scored against an arithmetic requantization model.
module tb_ofm_writer;

    localparam int ACC_W      = 20;
    localparam int OUT_W      = 8;
    localparam int ADDR_W     = 8;
    localparam int OFM_WORDS  = 176;
    localparam int SHIFT      = 4;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  in_data;
    logic [ADDR_W-1:0] address;
    logic [OUT_W-1:0]  wrData;
    logic              wren;
    logic              busy;
    logic              done;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int acc_n    = 0;
    int wr_n     = 0;
    int exp_addr = 0;
    int exp_q[$];

    typedef struct {
        int din;
        int exp;
    } vec_t;
    vec_t vec[6];

    always #5 clk = ~clk;

    ofm_writer #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .ADDR_W     (ADDR_W),
        .OFM_WORDS  (OFM_WORDS),
        .SHIFT      (SHIFT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .address  (address),
        .wrData   (wrData),
        .wren     (wren),
        .busy     (busy),
        .done     (done)
    );

    // floor((x + 2^(SHIFT-1)) / 2^SHIFT), clamped to the signed 8-bit range
    function automatic int model(input int x);
        int d;
        int n;
        int t;
        d = 1 << SHIFT;
        n = x + d / 2;
        if (n >= 0) t = n / d;
        else        t = -((-n + d - 1) / d);
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
`ifdef OFM_WRITER_RELU_EN
        if (t < 0) t = 0;
`endif
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: log any transfer about to happen, then score any write that appears.
    task automatic tick();
        int sx;
        if (in_valid && in_ready) begin
            sx = $signed(in_data);
            exp_q.push_back(model(sx));
            acc_n++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (wren) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                chk("sb_data", $signed(wrData), exp_q.pop_front());
                chk("sb_addr", int'(address), exp_addr);
            end
            exp_addr++;
            wr_n++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start    = 1'b0;
        exp_addr = 0;
        acc_n    = 0;
        wr_n     = 0;
    endtask

    initial begin
        int first_wr;
        int last_wr;
        int nwr;

        vec[0] = '{din: 55,    exp: 3};
        vec[1] = '{din: 5000,  exp: 8'h7F};
        vec[2] = '{din: 8,     exp: 1};
        vec[3] = '{din: 7,     exp: 0};
`ifdef OFM_WRITER_RELU_EN
        vec[4] = '{din: -24,   exp: 8'h00};
        vec[5] = '{din: -5000, exp: 8'h00};
`else
        vec[4] = '{din: -24,   exp: 8'hFF};
        vec[5] = '{din: -5000, exp: 8'h80};
`endif

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_address", int'(address), 0);
        chk("rst_wrData", int'(wrData), 0);
        chk("rst_wren", wren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // IDLE ignores input
        in_valid = 1'b1;
        in_data  = ACC_W'(123);
        for (int i = 0; i < 3; i++) begin
            chk("idle_in_ready", in_ready, 0);
            tick();
            chk("idle_wren", wren, 0);
        end
        in_valid = 1'b0;

        // run 1: burst fill, quantize table, then randomized remainder
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);

        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            in_data  = ACC_W'($urandom_range(0, 4095) - 2048);
            chk("burst_rdy", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("burst_writes", wr_n, 4);

        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = ACC_W'(vec[k].din);
            chk("q_rdy", in_ready, 1);
            tick();
            in_valid = 1'b0;
            chk("q_lat_early", wren, 0);
            tick();
            chk("q_lat_one", wren, 1);
            chk("q_addr", int'(address), 4 + k);
            chk("q_data", int'(wrData), vec[k].exp);
        end

        for (int c = 0; c < 3000 && !done; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) in_data = ACC_W'($urandom);
            else                           in_data = ACC_W'($urandom_range(0, 4095) - 2048);
            start = (c == 40);
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        chk("rnd_done", done, 1);
        chk("rnd_accepts", acc_n, OFM_WORDS);
        chk("rnd_writes", wr_n, OFM_WORDS);
        chk("rnd_pending", exp_q.size(), 0);

        // run 2: restart from DONE, full map with in_data = 16*i
        pulse_start();
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 1);
        first_wr = -1;
        last_wr  = -1;
        nwr      = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            in_valid = 1'b1;
            in_data  = ACC_W'(16 * acc_n);
            if (acc_n < OFM_WORDS) chk("map_rdy_hold", in_ready, 1);
            tick();
            if (wren) begin
                chk("map_addr", int'(address), nwr);
                chk("map_data", int'(wrData), (nwr > 127) ? 127 : nwr);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                nwr++;
                if (nwr == OFM_WORDS) begin
                    chk("map_busy_last", busy, 1);
                    chk("map_done_last", done, 0);
                end
            end
        end
        chk("map_done", done, 1);
        chk("map_busy_after", busy, 0);
        chk("map_wren_after", wren, 0);
        chk("map_nwr", nwr, OFM_WORDS);
        chk("map_consecutive", last_wr - first_wr + 1, OFM_WORDS);
        repeat (2) tick();
        chk("map_no_177th", acc_n, OFM_WORDS);
        chk("map_rdy_low", in_ready, 0);
        chk("map_done_hold", done, 1);

        // run 3: reset after 50 writes, then restart at address 0
        pulse_start();
        for (int c = 0; c < 200 && wr_n < 50; c++) begin
            in_valid = 1'b1;
            in_data  = ACC_W'($urandom);
            tick();
        end
        chk("mid_writes", wr_n, 50);
        rst = 1'b1;
        #1;
        chk("mid_rst_wren", wren, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", int'(address), 0);
        chk("mid_rst_rdy", in_ready, 0);
        exp_q.delete();
        repeat (2) tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        chk("post_rst_done", done, 0);
        pulse_start();
        in_valid = 1'b1;
        in_data  = ACC_W'(40);
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_wren", wren, 1);
        chk("post_rst_addr", int'(address), 0);
        chk("post_rst_data", int'(wrData), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ofm_writer.md
# ofm_writer

Write-back stage directly upstream of the output-feature-map memory. It accepts signed accumulator results from the convolution datapath over a valid/ready handshake and requantizes each one to signed 8-bit with round-half-up and saturation. Results are buffered in a small FIFO and drive the OFM memory write port (`address`, `wrData`, `wren`) with sequential addresses 0..OFM_WORDS-1. The block reports completion once the whole feature map has been written.

## Interface
- `ACC_W`, 20: accumulator input width (signed).
- `OUT_W`, 8: output pixel width (signed).
- `ADDR_W`, 8: OFM address width.
- `OFM_WORDS`, 176: pixels per feature map (44 rows x 4 columns).
- `SHIFT`, 4: requantization right shift; range 1..ACC_W-OUT_W.
- `FIFO_DEPTH`, 4: entries in the internal buffer; power of two.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: single-cycle pulse that begins a feature-map write.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: block accepts `in_data` this cycle.
- `in_data`, in, ACC_W: signed accumulator result.
- `address`, out, ADDR_W: OFM write address.
- `wrData`, out, OUT_W: OFM write data.
- `wren`, out, 1: OFM write enable.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.

## Operation
- **FSM states**: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE on the cycle the write at address OFM_WORDS-1 is issued.
  - DONE -> RUN on `start`.
  - `start` in RUN is ignored.
- **Entering RUN**: clears the accept counter (`acc_cnt`) and the write counter (`wr_cnt`). The FIFO is empty at this point by construction.
- **Input handshake**: `in_ready` = RUN && FIFO not full && `acc_cnt` < OFM_WORDS. A transfer occurs when `in_valid && in_ready`. `in_ready` is 0 in IDLE and DONE. Excess inputs are never accepted.
- **Requantize, on every accepted sample** (combinational, before the FIFO push):
  - t = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed at ACC_W+1 bits so the add cannot overflow.
  - Saturate to [-128, 127].
- **Write side**: when RUN and the FIFO is non-empty, pop one entry per cycle. The registered outputs then present `wren`=1, `address`=`wr_cnt`, `wrData`=entry, and `wr_cnt` increments. Otherwise `wren`=0 and `address`/`wrData` hold their last values.
- **Simultaneous push and pop** on the same cycle are both allowed. A push into a full FIFO never happens, because `in_ready` is low.
- **Address**: never wraps within a run. `wr_cnt` stops at OFM_WORDS and resets only on the next `start`.
- **Reset, including mid-run**: state IDLE, FIFO emptied, both counters 0. All outputs reset to 0: `in_ready`, `address`, `wrData`, `wren`, `busy`, `done`. No partial write is issued after reset asserts.

## Timing
- Sample accepted at edge N -> `wren` high in cycle N+1 when the FIFO was empty. Latency is one cycle.
- Throughput is one sample per cycle with `in_valid` held high. There are no bubbles.
- `done` rises in the cycle after the final `wren` cycle and stays high until `start` or `rst`.
- `busy` is high from the cycle after `start` up to and including the final `wren` cycle.
- A downstream write with `address`=k always corresponds to the k-th accepted sample, counting from 0.

## Configuration
- `OFM_WRITER_RELU_EN` defined: after saturation, negative results are forced to 0, so the output range is [0, 127].
- Not defined: the signed saturated value passes unchanged.
- The macro changes no ports or timing.

## Structure
- Shared package `cnn_pkg`:
  - widths ACC_W, OUT_W, ADDR_W;
  - OFM_WORDS;
  - FSM state enum `ofm_wr_state_t`;
  - saturation bounds OUT_MAX = 127 and OUT_MIN = -128.
- Sub-module `ofm_fifo`: synchronous FIFO with parameters WIDTH and DEPTH. Ports: push, pop, din, dout, full, empty. Asynchronous reset to empty.
- The requantizer is a function in `cnn_pkg`, not a separate module.

## Test plan
- **Reset**: assert `rst` -> all outputs 0 and FSM in IDLE. Assert `in_valid` in IDLE -> `in_ready`=0 and no `wren`.
- **Quantize**, SHIFT=4, single samples:
  - 55 -> `wrData`=3;
  - -24 -> 0xFF, or 0x00 with `OFM_WRITER_RELU_EN`;
  - 5000 -> 0x7F;
  - -5000 -> 0x80, or 0x00 with `OFM_WRITER_RELU_EN`;
  - 8 -> 1; 7 -> 0.
- **Full map**: `start`, then `in_valid`=1 continuously with `in_data`=16·i -> 176 consecutive `wren` cycles with `address` 0..175 and `wrData`=i mod-saturated to 127. `done` follows the last write, and the 177th sample is not accepted.
- **Burst fill**: 4 samples accepted back-to-back at rate one per cycle, then `in_valid` dropped -> exactly 4 writes at addresses 0..3 in order. With `in_valid` held high, `in_ready` never drops and no write is lost.
- **Reset mid-run**: assert `rst` after 50 writes -> `wren` is 0 from the reset edge. A following `start` restarts writes at `address`=0.
- **Restart**: `start` pulsed in DONE -> `done`=0 and `busy`=1 next cycle, with addresses restarting at 0. A `start` pulsed in RUN has no effect on `address` continuity.
